// File: rtl/display_pkg.sv
// Shared types and constants for the display datapath: converter FSM states,
// the blank digit code understood by the 7-segment decoder, and counter sizing.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // The counter must be able to hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the multiplexed
// 7-segment display; the digit register only changes when a conversion ends.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W:0]     bcd_wide;
  logic [CNT_W-1:0]   cnt_q;
  logic               guard_nonzero;

  for (genvar i = 0; i <= DIGITS; i++) begin : g_adj
    bcd_add3 u_add3 (
      .nibble   (bcd_q[4*i +: 4]),
      .adjusted (bcd_adj[4*i +: 4])
    );
  end

  // Kept one bit wider than the accumulator so a bit that would fall off the
  // guard digit still registers as overflow instead of vanishing silently.
  assign bcd_wide      = {bcd_adj, shift_q[WIDTH-1]};
  assign guard_nonzero = |bcd_wide[BCD_W:4*DIGITS];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      digits  <= '0;
    end else begin
      // NOTE: done gets a default here so it pulses for exactly one cycle
      // without every branch having to clear it.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_q <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          bcd_q   <= bcd_wide[BCD_W-1:0];
          shift_q <= {shift_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_SHIFT) begin
            // Final shift: publish the result so it is valid while done is high.
            state <= DONE;
            done  <= 1'b1;
            if (guard_nonzero) begin
              digits <= {DIGITS{DIGIT_BLANK}};
              ovf    <= 1'b1;
            end else begin
              digits <= bcd_wide[4*DIGITS-1:0];
              ovf    <= 1'b0;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 14;
  localparam int DIGITS = 4;

  logic                Clk;
  logic                Reset;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [4*DIGITS-1:0] digits;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .digits (digits)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Decimal reference: values beyond the display range show dashes and ovf.
  task automatic model(input int v, output logic [15:0] d, output logic o);
    int p;
    p = 1;
    d = '0;
    o = 1'b0;
    if (v > 9999) begin
      d = 16'hFFFF;
      o = 1'b1;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        d[4*i +: 4] = 4'((v / p) % 10);
        p = p * 10;
      end
    end
  endtask

  // Called at a negedge with the DUT idle; start is accepted on the next posedge.
  task automatic convert(input int v, input string tag);
    logic [15:0] exp_d;
    logic        exp_o;
    logic [15:0] prev;
    int          rel;
    bit          seen;
    bit          held;
    model(v, exp_d, exp_o);
    prev  = digits;
    bin   = WIDTH'(v);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    bin   = WIDTH'($urandom);
    rel   = 1;
    check({tag, "_busy_accept"}, busy, 1);
    check({tag, "_done_early"}, done, 0);
    seen = 0;
    held = 1;
    while (!seen && rel < 40) begin
      if (done) seen = 1;
      else begin
        if (digits !== prev) held = 0;
        @(negedge Clk);
        rel++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, rel, 15);
    check({tag, "_held"}, held, 1);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_digits"}, digits, exp_d);
    check({tag, "_ovf"}, ovf, exp_o);
    @(negedge Clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_after"}, done, 0);
    check({tag, "_digits_kept"}, digits, exp_d);
  endtask

  initial begin
    int dones;
    int t1;
    int t2;
    int cyc;
    int v;
    Reset = 1'b0;
    start = 1'b0;
    bin   = '0;

    // Reset and idle
    repeat (3) @(negedge Clk);
    check("rst_busy", busy, 0);
    check("rst_digits", digits, 16'h0000);
    Reset = 1'b1;
    @(negedge Clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_ovf", ovf, 0);
    check("idle_digits", digits, 16'h0000);
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (done) dones++;
    end
    check("idle_no_done", dones, 0);

    // Directed values, including range boundaries and overflow recovery
    convert(1234, "d1234");
    convert(0, "d0");
    convert(9999, "d9999");
    convert(16383, "d16383");
    convert(10000, "d10000");
    convert(42, "d42");

    // start while busy is ignored, bin changes after capture have no effect
    bin   = 14'd555;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    dones = 0;
    for (int i = 1; i < 40; i++) begin
      if (i == 5) begin
        bin   = 14'd777;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) dones++;
      @(negedge Clk);
    end
    start = 1'b0;
    check("ign_one_done", dones, 1);
    check("ign_digits", digits, 16'h0555);
    convert(777, "d777");

    // Asynchronous reset mid-conversion
    bin   = 14'd1234;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (6) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ovf", ovf, 0);
    check("arst_digits", digits, 16'h0000);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (done) dones++;
    end
    check("arst_no_done", dones, 0);
    check("arst_idle_busy", busy, 0);
    convert(1234, "arst_d1234");

    // Held start: one conversion per WIDTH+2 cycles
    bin   = 14'd321;
    start = 1'b1;
    cyc   = 0;
    t1    = -1;
    t2    = -1;
    while (t2 < 0 && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    start = 1'b0;
    check("b2b_two_dones", (t1 >= 0 && t2 >= 0), 1);
    check("b2b_period", t2 - t1, WIDTH + 2);
    check("b2b_digits", digits, 16'h0321);
    repeat (20) @(negedge Clk);
    check("b2b_idle", busy, 0);

    // Random values across the whole input range and the displayable range
    for (int i = 0; i < 24; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
      convert(v, $sformatf("rnd%0d_%0d", i, v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
